// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared encodings and helpers for the mac_pipe multiply-
//               accumulate unit: instruction class / sub-class codes, dtsts
//               bit positions, accumulator width and select-width functions,
//               and the arithmetic mode enumeration.
// Ports       : none (package)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package mac_pkg;

   // Instruction class (ps_mac_cls)
   localparam logic [1:0] CLS_XFER = 2'b00;   // MR transfer / saturate
   localparam logic [1:0] CLS_PROD = 2'b01;   // plain product
   localparam logic [1:0] CLS_ADD  = 2'b10;   // MR + product
   localparam logic [1:0] CLS_SUB  = 2'b11;   // MR - product

   // Transfer sub-class (ps_mac_sc), meaningful only for CLS_XFER
   localparam logic [1:0] SC_MR0 = 2'b00;
   localparam logic [1:0] SC_MR1 = 2'b01;
   localparam logic [1:0] SC_MR2 = 2'b10;
   localparam logic [1:0] SC_SAT = 2'b11;

   // Bit positions inside ps_mac_dtsts
   localparam int DT_RY_SGN = 3;
   localparam int DT_RX_SGN = 2;
   localparam int DT_FRAC   = 1;
   localparam int DT_RND    = 0;

   // Arithmetic mode: {signed, fractional}
   typedef enum logic [1:0] {
      MODE_UI = 2'b00,
      MODE_UF = 2'b01,
      MODE_SI = 2'b10,
      MODE_SF = 2'b11
   } mode_t;

   // Accumulator width: double-width product plus guard bits
   function automatic int mr_width(input int d, input int g);
      return 2 * d + g;
   endfunction

   // Width of the MR select field; at least one bit even with a single MR
   function automatic int mrsel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_ovf_sat.sv
`default_nettype none
// ============================================================================
// Module      : mac_ovf_sat
// Description : Combinational overflow detector and saturator for a W-bit
//               accumulator value. The same instance feeds the mv flag and
//               the SAT instruction.
// Ports       : value     in  W  accumulator-width value under test
//               mode      in  2  UI / UF / SI / SF
//               ovf       out 1  value does not fit the mode's result range
//               sat_value out W  mode max or min, chosen by the sign bit
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mac_ovf_sat
   import mac_pkg::*;
#(
   parameter  int DATASIZE = 16,
   parameter  int GUARD    = 8,
   localparam int W        = mr_width(DATASIZE, GUARD)
)(
   input  logic [W-1:0] value,
   input  mode_t        mode,
   output logic         ovf,
   output logic [W-1:0] sat_value
);

   localparam int D = DATASIZE;

   logic neg;
   assign neg = value[W-1];

   // For the unsigned modes a set MSB can only come from a wrapped
   // subtraction, so it is treated as an underflow and clamps to zero.
   always_comb begin
      ovf       = 1'b0;
      sat_value = value;
      case (mode)
         MODE_UI: begin
            ovf       = |value[W-1:D];
            sat_value = neg ? '0 : {{(W-D){1'b0}}, {D{1'b1}}};
         end
         MODE_UF: begin
            ovf       = |value[W-1:2*D];
            sat_value = neg ? '0 : {{GUARD{1'b0}}, {(2*D){1'b1}}};
         end
         MODE_SI: begin
            ovf       = !((&value[W-1:D-1]) || !(|value[W-1:D-1]));
            sat_value = neg ? {{(W-D+1){1'b1}}, {(D-1){1'b0}}}
                            : {{(W-D+1){1'b0}}, {(D-1){1'b1}}};
         end
         MODE_SF: begin
            ovf       = !((&value[W-1:2*D-1]) || !(|value[W-1:2*D-1]));
            sat_value = neg ? {{(GUARD+1){1'b1}}, {(2*D-1){1'b0}}}
                            : {{(GUARD+1){1'b0}}, {(2*D-1){1'b1}}};
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mac_pipe
// Description : Two-stage pipelined multiply-accumulate unit with NUM_MR
//               accumulator registers, stall, registered valid strobe and
//               per-MR sticky overflow flags.
//               Stage 1 latches control and forms the 2D-bit product;
//               stage 2 reads MR[mrsel], computes, writes MR and registers
//               the Rn result and flags.
// Ports       : clk, reset (async, active-low)
//               ps_mac_en/stall/cls/sc/dtsts/otreg/mrsel/clrmvs  control in
//               xb_dtx, xb_dty                                   operands in
//               mac_xb_dt                                        Rn result
//               mac_ps_valid, mac_ps_mv, mac_ps_mn, mac_ps_mvs   status out
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mac_pipe
   import mac_pkg::*;
#(
   parameter int DATASIZE = 16,
   parameter int GUARD    = 8,
   parameter int NUM_MR   = 2
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ps_mac_en,
   input  logic                             ps_mac_stall,
   input  logic [1:0]                       ps_mac_cls,
   input  logic [1:0]                       ps_mac_sc,
   input  logic [3:0]                       ps_mac_dtsts,
   input  logic                             ps_mac_otreg,
   input  logic [mrsel_width(NUM_MR)-1:0]   ps_mac_mrsel,
   input  logic                             ps_mac_clrmvs,
   input  logic [DATASIZE-1:0]              xb_dtx,
   input  logic [DATASIZE-1:0]              xb_dty,
   output logic [DATASIZE-1:0]              mac_xb_dt,
   output logic                             mac_ps_valid,
   output logic                             mac_ps_mv,
   output logic                             mac_ps_mn,
   output logic [NUM_MR-1:0]                mac_ps_mvs
);

   localparam int D    = DATASIZE;
   localparam int W    = mr_width(DATASIZE, GUARD);
   localparam int SELW = mrsel_width(NUM_MR);

   // ---------------------------------------------------------------- stage 1
   logic           sx, sy, frac, rnd;
   logic [2*D-1:0] x_ext, y_ext, prod_raw, prod_adj, prod_s1;
   logic [D-1:0]   prod_hi_rnd;

   assign sx   = ps_mac_dtsts[DT_RX_SGN];
   assign sy   = ps_mac_dtsts[DT_RY_SGN];
   assign frac = ps_mac_dtsts[DT_FRAC];
   assign rnd  = ps_mac_dtsts[DT_RND];

   // Extending both operands to 2D bits keeps the low 2D product bits exact
   // for any signed/unsigned mix.
   always_comb begin
      x_ext       = {{D{sx & xb_dtx[D-1]}}, xb_dtx};
      y_ext       = {{D{sy & xb_dty[D-1]}}, xb_dty};
      prod_raw    = x_ext * y_ext;
      prod_adj    = (sx & sy & frac) ? (prod_raw << 1) : prod_raw;
      // Adding 2^(D-1) and clearing the low half equals the upper half plus
      // the carry out of bit D-1.
      prod_hi_rnd = prod_adj[2*D-1:D] + {{(D-1){1'b0}}, prod_adj[D-1]};
      prod_s1     = (frac & rnd) ? {prod_hi_rnd, {D{1'b0}}} : prod_adj;
   end

   logic            s1_valid, s1_sgn, s1_frac, s1_otreg;
   logic [1:0]      s1_cls, s1_sc;
   logic [SELW-1:0] s1_mrsel;
   logic [2*D-1:0]  s1_prod;
   logic [D-1:0]    s1_rx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_sgn   <= 1'b0;
         s1_frac  <= 1'b0;
         s1_otreg <= 1'b0;
         s1_cls   <= '0;
         s1_sc    <= '0;
         s1_mrsel <= '0;
         s1_prod  <= '0;
         s1_rx    <= '0;
      end else if (!ps_mac_stall) begin
         s1_valid <= ps_mac_en;
         if (ps_mac_en) begin
            s1_sgn   <= sx | sy;
            s1_frac  <= frac;
            s1_otreg <= ps_mac_otreg;
            s1_cls   <= ps_mac_cls;
            s1_sc    <= ps_mac_sc;
            s1_mrsel <= ps_mac_mrsel;
            s1_prod  <= prod_s1;
            s1_rx    <= xb_dtx;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [W-1:0] mr [NUM_MR];
   logic [W-1:0] mr_rd, prod_ext, ovf_in, sat_value, result, mr2_load;
   logic [D-1:0] mr2_slice, rn;
   logic         ovf, xfer_slice, mv, mn;
   mode_t        mode;

   // Out-of-range selects (non power-of-two NUM_MR) read as zero.
   always_comb begin
      mr_rd = '0;
      for (int i = 0; i < NUM_MR; i++) begin
         if (s1_mrsel == SELW'(i)) mr_rd = mr[i];
      end
   end

   // MR2 slice: guard bits sign-extended from bit W-1 (narrow guard) or
   // truncated (guard at least as wide as Rn).
   if (GUARD < D) begin : g_guard_narrow
      assign mr2_slice = {{(D-GUARD){mr_rd[W-1]}}, mr_rd[W-1:2*D]};
      assign mr2_load  = {s1_rx[GUARD-1:0], {(2*D){1'b0}}};
   end else begin : g_guard_wide
      assign mr2_slice = mr_rd[3*D-1:2*D];
      assign mr2_load  = W'({s1_rx, {(2*D){1'b0}}});
   end

   assign mode = mode_t'({s1_sgn, s1_frac});

   mac_ovf_sat #(
      .DATASIZE (DATASIZE),
      .GUARD    (GUARD)
   ) u_ovf_sat (
      .value     (ovf_in),
      .mode      (mode),
      .ovf       (ovf),
      .sat_value (sat_value)
   );

   always_comb begin
      prod_ext = s1_sgn ? {{GUARD{s1_prod[2*D-1]}}, s1_prod}
                        : {{GUARD{1'b0}}, s1_prod};
      // Transfers feed the raw MR through the detector so SAT can use it.
      case (s1_cls)
         CLS_PROD: ovf_in = prod_ext;
         CLS_ADD:  ovf_in = mr_rd + prod_ext;
         CLS_SUB:  ovf_in = mr_rd - prod_ext;
         default:  ovf_in = mr_rd;
      endcase

      xfer_slice = (s1_cls == CLS_XFER) && (s1_sc != SC_SAT);

      result = ovf_in;
      if (s1_cls == CLS_XFER) begin
         case (s1_sc)
            SC_MR0:  result = {{(W-D){1'b0}}, s1_rx};
            SC_MR1:  result = {{GUARD{s1_rx[D-1]}}, s1_rx, {D{1'b0}}};
            SC_MR2:  result = mr2_load;
            default: result = ovf ? sat_value : mr_rd;
         endcase
      end

      rn = s1_frac ? result[2*D-1:D] : result[D-1:0];
      if (xfer_slice) begin
         case (s1_sc)
            SC_MR0:  rn = mr_rd[D-1:0];
            SC_MR1:  rn = mr_rd[2*D-1:D];
            default: rn = mr2_slice;
         endcase
      end

      mv = !xfer_slice && ovf;
      mn = !xfer_slice && s1_sgn && result[W-1];
   end

   // MR file and sticky flags; set beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_MR; i++) mr[i] <= '0;
         mac_ps_mvs <= '0;
      end else if (!ps_mac_stall) begin
         for (int i = 0; i < NUM_MR; i++) begin
            if (s1_valid && s1_otreg && (s1_mrsel == SELW'(i))) begin
               mr[i] <= result;
               mac_ps_mvs[i] <= mv | (mac_ps_mvs[i] & ~ps_mac_clrmvs);
            end else begin
               mac_ps_mvs[i] <= mac_ps_mvs[i] & ~ps_mac_clrmvs;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mac_xb_dt    <= '0;
         mac_ps_valid <= 1'b0;
         mac_ps_mv    <= 1'b0;
         mac_ps_mn    <= 1'b0;
      end else if (!ps_mac_stall) begin
         mac_ps_valid <= s1_valid;
         if (s1_valid) begin
            mac_ps_mv <= mv;
            mac_ps_mn <= mn;
            if (!s1_otreg) mac_xb_dt <= rn;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mac_pipe.md
# mac_pipe

Two-stage pipelined multiply-accumulate unit for the compute block. It is the parametrised successor to the single-cycle multiplier: data width and guard-bit count are configurable, and there are NUM_MR selectable accumulator (MR) registers. It adds a stall input, a registered valid strobe and per-MR sticky overflow flags. It sits between the register-file crossbar (operands in, results out) and the program sequencer (control and flags).

## Interface
- DATASIZE, 16, operand and Rn result width (D)
- GUARD, 8, MR guard bits; MR width W = 2*D + GUARD
- NUM_MR, 2, number of accumulator registers (minimum 1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- ps_mac_en  in  1  issue strobe; instruction and operands are sampled this cycle
- ps_mac_stall  in  1  freezes both pipeline stages and all outputs
- ps_mac_cls  in  2  00 transfer/SAT, 01 product, 10 accumulate add, 11 accumulate subtract
- ps_mac_sc  in  2  only for cls 00: 00 MR0 slice, 01 MR1 slice, 10 MR2 slice, 11 SAT MR
- ps_mac_dtsts  in  4  [3] Ry signed, [2] Rx/MR signed, [1] fractional, [0] round
- ps_mac_otreg  in  1  0 result goes to Rn; 1 result written to MR
- ps_mac_mrsel  in  max(1,$clog2(NUM_MR))  target/source MR
- ps_mac_clrmvs  in  1  clears all sticky overflow flags
- xb_dtx, xb_dty  in  D  Rx, Ry operands
- mac_xb_dt  out  D  Rn result (registered, reset 0)
- mac_ps_valid  out  1  one-cycle result strobe (reset 0)
- mac_ps_mv, mac_ps_mn  out  1  overflow and sign flags of the result (reset 0)
- mac_ps_mvs  out  NUM_MR  sticky overflow flag per MR (reset 0)

## Operation
- Stage 1 (issue cycle N): latch control; compute the 2D-bit product from operands.
  - Signed operands use (D+1)-bit sign extension.
  - Signed fractional (both operands signed): product shifted left by 1.
  - Round (fractional only): add 2^(D-1), then clear bits [D-1:0].
- Stage 2 (cycle N+1): read MR[mrsel], then compute:
  - cls 01: product extended to W bits; sign-extended if either operand is signed, otherwise zero-extended.
  - cls 10: MR + product.
  - cls 11: MR − product.
  - cls 00, otreg=1: MR0 ← zero-extended Rx; MR1 ← sign-extended Rx << D; MR2 ← Rx[GUARD-1:0] << 2D.
  - cls 00 sc 11 (SAT): if MR overflows in the current mode, clamp MR to the mode max/min; otherwise MR is unchanged.
  - cls 00, otreg=0, sc ≠ 11: Rn ← selected MR slice. The MR2 slice is sign-extended from bit W-1.
- Rn data: fractional mode takes result[2D-1:D]; integer mode takes result[D-1:0].
- MR write happens only when otreg=1. Unselected MRs never change.
- Overflow test on the W-bit result:
  - UI: [W-1:D] ≠ 0.
  - UF: [W-1:2D] ≠ 0.
  - SI: [W-1:D-1] not all equal.
  - SF: [W-1:2D-1] not all equal.
- mn = (either operand signed) & result[W-1].
- mv and mn are forced to 0 for cls 00 with sc ≠ 11.
- Sticky flags: mvs[mrsel] is set when an MR-writing op has mv=1. clrmvs clears all flags. When set and clear occur in the same cycle, set wins.

## Timing
- Latency 2: issue at posedge N; MR is updated at the end of N+1; mac_xb_dt, flags and valid are presented during N+2.
- Back-to-back ops on the same MR need no forwarding because MR is read in stage 2. One issue per cycle is supported.
- Stall: all stage registers, MRs and outputs hold their values. mac_ps_valid stays high only if it was high when the stall began. ps_mac_en is ignored while stalled; PS holds the instruction.
- Reset (asynchronous, at any time, including mid-operation): stage valids, MRs, mvs and all outputs go to 0. In-flight ops are discarded.

## Structure
- Package mac_pkg holds:
  - cls and sc encodings;
  - dtsts bit indices;
  - MR width function W(D, GUARD);
  - the mode enum {UI, UF, SI, SF}.
- Sub-module mac_ovf_sat is combinational. It takes the W-bit value and the mode, and returns mv plus the clamped value. It is used for both the flags and SAT.

## Test plan
- Product, SSF, D=16: x=0x4000, y=0x4000, dtsts 1110, otreg 0 → at N+2: mac_xb_dt=0x2000, valid=1, mv=0, mn=0.
- Accumulate, UUI: clear MR1, then three back-to-back cls 10 ops with mrsel 1, x=y=0xFFFF, otreg 1 → MR1=0x02_FFFA_0003, mv=1, mvs=2'b10, MR0 unchanged.
- SAT, SI: write MR1 with Rx=0x0001 (MR0=0x00_0001_0000), then SAT (dtsts 1100) → MR0=0x00_0000_7FFF; a following MR0 slice read → 0x7FFF.
- Stall: issue a product, then hold stall for 3 cycles starting at N+1 → valid appears at N+5 with unchanged data; an en pulse issued during the stall produces no result.
- Reset mid-op: assert reset with two ops in flight → valid, outputs, MRs and mvs are 0; the first op after release completes with normal latency.
- Sticky: overflow set and clrmvs in the same cycle → mvs bit is 1; clrmvs alone on the next cycle → 0.
